shift_add_multiplier: RTL
=========================

# shift_add_multiplier

- Iterative shift-and-add multiplier with valid/ready handshakes on input and output.
- Consumes one operand pair and produces a full double-width product after a fixed number of cycles.
- Sits directly downstream of the shifter stage: each iteration applies a 1-bit logical left shift to the multiplicand and a 1-bit logical right shift to the multiplier, then conditionally accumulates.
- Supports unsigned and two's-complement signed operands, selected per transaction.

## Interface

Parameters:
- `width`, default 32: operand width; must be a power of two, at least 4.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: operand pair is presented.
- `in_ready`, output, 1: block can accept an operand pair.
- `a`, input, `width`: multiplicand.
- `b`, input, `width`: multiplier.
- `is_signed`, input, 1: 1 treats `a` and `b` as two's complement; 0 treats them as unsigned.
- `out_valid`, output, 1: `product` holds a finished result.
- `out_ready`, input, 1: downstream accepts `product`.
- `product`, output, 2*`width`: full product (signed or unsigned per the accepted `is_signed`).

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid` && `in_ready`: latch `mcand` = |a| zero-extended to 2*`width`, and `mplier` = |b| (`width` bits).
  - Magnitudes are taken only if `is_signed`; otherwise raw values are used.
  - Set `neg` = `is_signed` & (a[msb] ^ b[msb]); clear `acc` and `count`; go to BUSY.
- BUSY, one iteration per cycle:
  - If `mplier`[0], then `acc` += `mcand` (2*`width`-bit add; carry out is discarded and cannot occur).
  - Then `mcand` <<= 1 and `mplier` >>= 1 (both logical), and `count`++.
  - Exactly `width` iterations; no early termination.
  - On the final iteration: `product` <= `neg` ? -(acc_next) : acc_next, then go to DONE.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - `product` holds stable until `out_valid` && `out_ready`, then go to IDLE.
- `in_ready` = (state == IDLE), combinational from state only.
  - A new pair is never accepted in the same cycle as the output handshake.
- Operands `a`, `b` and `is_signed` are sampled only at the accept edge; changes during BUSY/DONE are ignored.
- Magnitude of the most negative value -2^(`width`-1) is 2^(`width`-1), which fits unsigned in `width` bits. No special case is needed.
  - Signed (-2^(w-1))^2 = 2^(2w-2) is representable.
- `count` is a clog2(`width`)+1-bit counter; comparison is with `width`-1 on the final iteration.
- Reset, asserted at any time including mid-BUSY or DONE:
  - State goes to IDLE, and any in-flight result is discarded with no `out_valid` pulse.
  - All outputs reset: `out_valid`=0, `product`=0, `in_ready`=1.
  - Internal registers `acc`, `mcand`, `mplier`, `count`, `neg` reset to 0.

## Timing

- Accept edge at the end of cycle 0; BUSY occupies cycles 1..`width`; `out_valid` rises in cycle `width`+1 (cycle 33 for `width`=32).
- Latency from accept to `out_valid` is `width`+1 cycles. Throughput is one result per `width`+2 cycles minimum, with `out_ready` held high.
- `product` is registered, with no combinational path from inputs to outputs.
- `out_ready` held low stalls indefinitely in DONE.
- After the output handshake, `in_ready` is 1 in the next cycle.

## Structure

- Package `mul_pkg`:
  - `state_t` enum (IDLE, BUSY, DONE).
  - Localparam helpers for product width (2*`width`) and counter width.
- Shift steps instantiate the existing `lshifter` (shamt_width = clog2(2*`width`)) and `rlshifter` (shamt_width = clog2(`width`)), each with constant shamt 1.
- No other sub-module. Magnitude/negate and the accumulate adder are inline.

## Test plan

- Unsigned 3 × 5, `out_ready`=1 → `product`=0x0000_0000_0000_000F, with `out_valid` first high at cycle 33 after the accept.
- Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001.
- Signed -7 × 6 (0xFFFF_FFF9, 0x6) → 0xFFFF_FFFF_FFFF_FFD6; signed 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000.
- Backpressure: `out_ready`=0 for 10 cycles in DONE with `in_valid`=1 and changing `a`/`b`:
  - `product` stays stable, `in_ready`=0, and no accept occurs.
  - After `out_ready` pulses, `in_ready`=1 next cycle and the next pair is accepted.
- Reset: `rst_n` low during BUSY cycle 10:
  - `out_valid`=0, `product`=0 and `in_ready`=1 immediately, with no result emitted.
  - A following 12 × 12 run yields 0x90.
- Back-to-back random signed/unsigned pairs (≥1000) versus a reference product, checking handshake counts are equal and results are in order.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mul_pkg;

  // Controller states: waiting for operands, iterating, holding a result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the full double-width product for a given operand width
  function automatic int prodWidth(input int w);
    return 2 * w;
  endfunction

  // Iteration counter width: enough to hold 0..w
  function automatic int cntWidth(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/lshifter.sv
// Logical left shifter, zero-filled from the right.
module lshifter #(
  parameter int width       = 64,
  parameter int shamt_width = 6
) (
  input  logic [width-1:0]       din_i,
  input  logic [shamt_width-1:0] shamt_i,
  output logic [width-1:0]       dout_o
);

  assign dout_o = din_i << shamt_i;

endmodule

// File: rtl/rlshifter.sv
// Logical right shifter, zero-filled from the left.
module rlshifter #(
  parameter int width       = 32,
  parameter int shamt_width = 5
) (
  input  logic [width-1:0]       din_i,
  input  logic [shamt_width-1:0] shamt_i,
  output logic [width-1:0]       dout_o
);

  assign dout_o = din_i >> shamt_i;

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add multiplier, one partial product per cycle,
// with valid/ready handshakes on both sides and signed/unsigned operation
// chosen per transaction. Signed operands are multiplied as magnitudes and
// the sign is re-applied once at the end.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   product
);

  localparam int PW  = prodWidth(width);
  localparam int CW  = cntWidth(width);
  localparam int LSW = $clog2(PW);
  localparam int RSW = $clog2(width);

  state_t           state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [width-1:0] mplier_q;
  logic [CW-1:0]    count_q;
  logic             neg_q;
  logic [PW-1:0]    product_q;
  logic             out_valid_q;

  logic [width-1:0] a_mag_d;
  logic [width-1:0] b_mag_d;
  logic             neg_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    product_d;
  logic [PW-1:0]    mcand_shl;
  logic [width-1:0] mplier_shr;
  logic             last_iter;

  // Per-iteration shifts of the multiplicand and multiplier
  lshifter #(
    .width       (PW),
    .shamt_width (LSW)
  ) u_mcand_shift (
    .din_i   (mcand_q),
    .shamt_i (LSW'(1)),
    .dout_o  (mcand_shl)
  );

  rlshifter #(
    .width       (width),
    .shamt_width (RSW)
  ) u_mplier_shift (
    .din_i   (mplier_q),
    .shamt_i (RSW'(1)),
    .dout_o  (mplier_shr)
  );

  // Operand magnitudes, result sign, conditional accumulate and final sign fix-up
  always_comb begin
    a_mag_d   = (is_signed && a[width-1]) ? -a : a;
    b_mag_d   = (is_signed && b[width-1]) ? -b : b;
    neg_d     = is_signed & (a[width-1] ^ b[width-1]);
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    product_d = neg_q ? -acc_d : acc_d;
    last_iter = (count_q == CW'(width - 1));
  end

  // Controller and datapath registers; the most negative operand's magnitude
  // still fits unsigned in width bits, so no special case is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{width{1'b0}}, a_mag_d};
            mplier_q <= b_mag_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_shl;
          mplier_q <= mplier_shr;
          count_q  <= count_q + CW'(1);
          if (last_iter) begin
            product_q   <= product_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
